// File: rtl/ps2_kbd_ctrl_if.sv
// Host-receive, device-transmit and scan-code signals of the PS/2 keyboard personality.
// The slave modport is the sequencer; the master modport is whoever drives it.
interface ps2_kbd_ctrl_if;
    logic [7:0] rcv_data;
    logic       rcv_error;
    logic       rcv_ready;
    logic       xmt_ready;
    logic [7:0] xmt_data;
    logic       xmt_strobe;
    logic [7:0] key_data;
    logic       key_wr;
    logic       key_full;
    logic [2:0] leds;
    logic       enabled;

    modport slave (
        input  rcv_data,
        input  rcv_error,
        input  rcv_ready,
        input  xmt_ready,
        input  key_data,
        input  key_wr,
        output xmt_data,
        output xmt_strobe,
        output key_full,
        output leds,
        output enabled
    );

    modport master (
        output rcv_data,
        output rcv_error,
        output rcv_ready,
        output xmt_ready,
        output key_data,
        output key_wr,
        input  xmt_data,
        input  xmt_strobe,
        input  key_full,
        input  leds,
        input  enabled
    );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// Keyboard personality: decodes host commands and queues responses; responses take
// priority over scan codes from a small FIFO.
module ps2_kbd_ctrl #(
    parameter int unsigned FIFO_AW = 2,
    parameter logic [7:0]  ID_HI   = 8'hAB,
    parameter logic [7:0]  ID_LO   = 8'h83
) (
    input  logic           clk,
    input  logic           rst,
    ps2_kbd_ctrl_if.slave  bus
);

    localparam int unsigned FifoDepth = 1 << FIFO_AW;

    typedef enum logic {StRun, StArg} state_e;

    state_e             state_q;
    logic [7:0]         resp_q [3];
    logic [1:0]         resp_cnt_q;
    logic [7:0]         fifo_mem_q [FifoDepth];
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW:0]   fifo_cnt_q;
    logic [2:0]         leds_q;
    logic               enabled_q;
    logic [7:0]         last_q;

    logic       resp_valid;
    logic       fifo_valid;
    logic       fifo_full;
    logic       strobe;
    logic       pop_resp;
    logic       pop_fifo;
    logic       push_fifo;
    logic [7:0] head_data;

    always_comb begin
        resp_valid = (resp_cnt_q != 2'd0);
        fifo_full  = (fifo_cnt_q == (FIFO_AW + 1)'(FifoDepth));
        // Scan codes only flow while scanning is enabled and no LED argument is pending.
        fifo_valid = enabled_q && (state_q == StRun) && (fifo_cnt_q != '0);
        head_data  = 8'h00;
        if (resp_valid) begin
            head_data = resp_q[0];
        end else if (fifo_valid) begin
            head_data = fifo_mem_q[rd_ptr_q];
        end
        strobe    = bus.xmt_ready & (resp_valid | fifo_valid);
        pop_resp  = strobe & resp_valid;
        pop_fifo  = strobe & ~resp_valid;
        push_fifo = bus.key_wr & ~fifo_full;
    end

    assign bus.xmt_data   = head_data;
    assign bus.xmt_strobe = strobe;
    assign bus.key_full   = fifo_full;
    assign bus.leds       = leds_q;
    assign bus.enabled    = enabled_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            resp_q     <= '{8'hAA, 8'h00, 8'h00};
            resp_cnt_q <= 2'd1;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            leds_q     <= 3'b000;
            enabled_q  <= 1'b1;
            last_q     <= 8'hAA;
        end else begin
            if (pop_resp) begin
                resp_q[0]  <= resp_q[1];
                resp_q[1]  <= resp_q[2];
                resp_q[2]  <= 8'h00;
                resp_cnt_q <= resp_cnt_q - 2'd1;
            end
            if (strobe) begin
                last_q <= head_data;
            end

            if (push_fifo) begin
                fifo_mem_q[wr_ptr_q] <= bus.key_data;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (pop_fifo) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_fifo && !pop_fifo) begin
                fifo_cnt_q <= fifo_cnt_q + 1'b1;
            end else if (!push_fifo && pop_fifo) begin
                fifo_cnt_q <= fifo_cnt_q - 1'b1;
            end

            // A host byte replaces whatever is left of the response queue; placed after the
            // pop so the replacement wins, and FE reads last_q before this cycle's strobe.
            if (bus.rcv_ready) begin
                if (bus.rcv_error) begin
                    resp_q     <= '{8'hFE, 8'h00, 8'h00};
                    resp_cnt_q <= 2'd1;
                end else if (state_q == StArg) begin
                    leds_q     <= bus.rcv_data[2:0];
                    resp_q     <= '{8'hFA, 8'h00, 8'h00};
                    resp_cnt_q <= 2'd1;
                    state_q    <= StRun;
                end else begin
                    resp_cnt_q <= 2'd1;
                    case (bus.rcv_data)
                        8'hFF: begin
                            resp_q     <= '{8'hFA, 8'hAA, 8'h00};
                            resp_cnt_q <= 2'd2;
                            leds_q     <= 3'b000;
                            enabled_q  <= 1'b1;
                            rd_ptr_q   <= '0;
                            wr_ptr_q   <= '0;
                            fifo_cnt_q <= '0;
                        end
                        8'hF2: begin
                            resp_q     <= '{8'hFA, ID_HI, ID_LO};
                            resp_cnt_q <= 2'd3;
                        end
                        8'hF4: begin
                            resp_q    <= '{8'hFA, 8'h00, 8'h00};
                            enabled_q <= 1'b1;
                        end
                        8'hF5: begin
                            resp_q     <= '{8'hFA, 8'h00, 8'h00};
                            enabled_q  <= 1'b0;
                            rd_ptr_q   <= '0;
                            wr_ptr_q   <= '0;
                            fifo_cnt_q <= '0;
                        end
                        8'hED: begin
                            resp_q  <= '{8'hFA, 8'h00, 8'h00};
                            state_q <= StArg;
                        end
                        8'hEE:   resp_q <= '{8'hEE, 8'h00, 8'h00};
                        8'hFE:   resp_q <= '{last_q, 8'h00, 8'h00};
                        default: resp_q <= '{8'hFE, 8'h00, 8'h00};
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: directed command scenarios plus random traffic, all checked
// each cycle against a queue-based model of the keyboard personality.
module tb_ps2_kbd_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_kbd_ctrl_if bus ();

    ps2_kbd_ctrl #(
        .FIFO_AW (2),
        .ID_HI   (8'hAB),
        .ID_LO   (8'h83)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_rsp[$];
    logic [7:0] m_fifo[$];
    logic [2:0] m_leds;
    bit         m_en;
    bit         m_arg;
    logic [7:0] m_last;

    logic [7:0] sent[$];
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rsp  = {8'hAA};
        m_fifo = {};
        m_leds = 3'b000;
        m_en   = 1'b1;
        m_arg  = 1'b0;
        m_last = 8'hAA;
    endtask

    task automatic model_decode(input logic [7:0] d, input logic err);
        if (err) begin
            m_rsp = {8'hFE};
        end else if (m_arg) begin
            m_leds = d[2:0];
            m_rsp  = {8'hFA};
            m_arg  = 1'b0;
        end else begin
            case (d)
                8'hFF: begin m_rsp = {8'hFA, 8'hAA}; m_leds = 3'b000; m_en = 1'b1; m_fifo = {}; end
                8'hF2: m_rsp = {8'hFA, 8'hAB, 8'h83};
                8'hF4: begin m_rsp = {8'hFA}; m_en = 1'b1; end
                8'hF5: begin m_rsp = {8'hFA}; m_en = 1'b0; m_fifo = {}; end
                8'hED: begin m_rsp = {8'hFA}; m_arg = 1'b1; end
                8'hEE: m_rsp = {8'hEE};
                8'hFE: m_rsp = {m_last};
                default: m_rsp = {8'hFE};
            endcase
        end
    endtask

    // One clock: compare outputs at negedge against the model, then advance the model.
    task automatic tick();
        logic [7:0] hd;
        bit         hv;
        bit         from_rsp;
        bit         st;
        bit         full;
        @(negedge clk);
        hv = 1'b0;
        hd = 8'h00;
        from_rsp = 1'b0;
        if (m_rsp.size() > 0) begin
            hv = 1'b1; hd = m_rsp[0]; from_rsp = 1'b1;
        end else if (m_en && !m_arg && m_fifo.size() > 0) begin
            hv = 1'b1; hd = m_fifo[0];
        end
        st   = bus.xmt_ready && hv;
        full = (m_fifo.size() == 4);
        check("xmt_strobe", 32'(bus.xmt_strobe), 32'(st));
        check("xmt_data", 32'(bus.xmt_data), 32'(hd));
        check("key_full", 32'(bus.key_full), 32'(full));
        check("leds", 32'(bus.leds), 32'(m_leds));
        check("enabled", 32'(bus.enabled), 32'(m_en));
        if (bus.xmt_strobe) sent.push_back(bus.xmt_data);
        if (st) begin
            if (from_rsp) void'(m_rsp.pop_front());
            else void'(m_fifo.pop_front());
        end
        if (bus.key_wr && !full) m_fifo.push_back(bus.key_data);
        if (bus.rcv_ready) model_decode(bus.rcv_data, bus.rcv_error);
        if (st) m_last = hd;
        @(posedge clk);
        #1;
    endtask

    task automatic windows(input int n);
        for (int i = 0; i < n; i++) begin
            bus.xmt_ready = 1'b1;
            tick();
            bus.xmt_ready = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic host(input logic [7:0] d, input logic err);
        bus.rcv_ready = 1'b1;
        bus.rcv_data  = d;
        bus.rcv_error = err;
        tick();
        bus.rcv_ready = 1'b0;
        bus.rcv_data  = 8'h00;
        bus.rcv_error = 1'b0;
    endtask

    task automatic key_push(input logic [7:0] d);
        bus.key_wr   = 1'b1;
        bus.key_data = d;
        tick();
        bus.key_wr   = 1'b0;
        bus.key_data = 8'h00;
    endtask

    task automatic expect_sent(input string tag);
        check({tag, "_count"}, 32'(sent.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < sent.size()) check({tag, "_byte"}, 32'(sent[i]), 32'(exp_q[i]));
        end
        sent = {};
    endtask

    initial begin
        logic [7:0] cmds[9];
        cmds = '{8'hFF, 8'hF2, 8'hF4, 8'hF5, 8'hED, 8'hEE, 8'hFE, 8'h55, 8'h00};

        bus.rcv_data  = 8'h00;
        bus.rcv_error = 1'b0;
        bus.rcv_ready = 1'b0;
        bus.xmt_ready = 1'b0;
        bus.key_data  = 8'h00;
        bus.key_wr    = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Power-on BAT byte, exactly once
        repeat (3) tick();
        windows(3);
        exp_q = {8'hAA};
        expect_sent("bat");
        check("rst_leds", 32'(bus.leds), 32'd0);
        check("rst_enabled", 32'(bus.enabled), 32'd1);

        // Identify
        host(8'hF2, 1'b0);
        windows(4);
        exp_q = {8'hFA, 8'hAB, 8'h83};
        expect_sent("f2");

        // LED command; scan code held while the argument is pending
        host(8'hED, 1'b0);
        windows(2);
        key_push(8'h1C);
        windows(2);
        host(8'h05, 1'b0);
        windows(3);
        exp_q = {8'hFA, 8'hFA, 8'h1C};
        expect_sent("ed");
        check("leds_set", 32'(bus.leds), 32'h5);

        // FIFO overflow drops the fifth code
        key_push(8'h1C);
        key_push(8'hF0);
        key_push(8'h1C);
        key_push(8'h2A);
        key_push(8'h3B);
        check("fifo_full", 32'(bus.key_full), 32'd1);
        windows(6);
        exp_q = {8'h1C, 8'hF0, 8'h1C, 8'h2A};
        expect_sent("fifo");

        // Disable with a simultaneous push (flush wins), then re-enable
        bus.key_wr   = 1'b1;
        bus.key_data = 8'h1C;
        host(8'hF5, 1'b0);
        bus.key_wr   = 1'b0;
        windows(2);
        check("disabled", 32'(bus.enabled), 32'd0);
        host(8'hF4, 1'b0);
        windows(4);
        check("reenabled", 32'(bus.enabled), 32'd1);
        exp_q = {8'hFA, 8'hFA};
        expect_sent("f5f4");

        // Error, resend, unknown, echo
        host(8'h12, 1'b1);
        windows(2);
        host(8'hFE, 1'b0);
        windows(2);
        host(8'h55, 1'b0);
        windows(2);
        host(8'hEE, 1'b0);
        windows(2);
        exp_q = {8'hFE, 8'hFE, 8'hFE, 8'hEE};
        expect_sent("err");

        // Random traffic, including host bytes colliding with strobes
        for (int i = 0; i < 3000; i++) begin
            bus.xmt_ready = ($urandom_range(0, 2) == 0);
            bus.rcv_ready = ($urandom_range(0, 11) == 0);
            bus.rcv_error = bus.rcv_ready && ($urandom_range(0, 9) == 0);
            if (bus.rcv_ready) begin
                if ($urandom_range(0, 3) == 0) bus.rcv_data = 8'($urandom);
                else bus.rcv_data = cmds[$urandom_range(0, 8)];
            end else begin
                bus.rcv_data = 8'h00;
            end
            bus.key_wr   = ($urandom_range(0, 3) == 0);
            bus.key_data = 8'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
